// File: rtl/tick_toggle_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_toggle_divider
// Brief    : Synchronizes a raw tick level, detects its rising edges and
//            toggles q once every div (0 -> 1) accepted ticks, pulsing tc.
// Revision : 1.0 - initial release
// ============================================================================
module tick_toggle_divider #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             t,
    input  logic [WIDTH-1:0] div,
    input  logic             clear,
    output logic             q,
    output logic             tc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] r_sync_chain;
    logic                   r_prev;
    logic                   r_q;
    logic                   r_tc;
    logic [WIDTH-1:0]       r_count;

    logic                   w_sync;
    logic                   w_rise;
    logic [WIDTH-1:0]       w_div_eff;
    logic                   w_wrap;

    assign w_sync    = r_sync_chain[SYNC_STAGES-1];
    assign w_rise    = w_sync & ~r_prev;
    assign w_div_eff = (div == '0) ? C_ONE : div;
    // >= rather than == so a div lowered below count still wraps on the next tick
    assign w_wrap    = (r_count >= (w_div_eff - C_ONE));

    generate
        if (SYNC_STAGES > 1) begin : g_sync_multi
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sync_chain <= '0;
                    r_prev       <= 1'b0;
                end else begin
                    r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], tick_in};
                    r_prev       <= w_sync;
                end
            end
        end else begin : g_sync_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sync_chain <= '0;
                    r_prev       <= 1'b0;
                end else begin
                    r_sync_chain <= tick_in;
                    r_prev       <= w_sync;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_q     <= 1'b0;
            r_tc    <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_q     <= 1'b0;
            r_tc    <= 1'b0;
        end else if (w_rise && t && w_wrap) begin
            r_count <= '0;
            r_q     <= ~r_q;
            r_tc    <= 1'b1;
        end else if (w_rise && t) begin
            r_count <= r_count + C_ONE;
            r_tc    <= 1'b0;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign q     = r_q;
    assign tc    = r_tc;
    assign count = r_count;

endmodule
`default_nettype wire
